// File: rtl/apb_bridge_pkg.sv
// Shared types and field layout for the APB bridge request/response FIFOs.
// Request entry: {write, addr, strb, data}. Response entry: {slverr, data}.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SETUP  = 2'd2,
        ACCESS = 2'd3
    } apb_state_e;

    localparam int REQ_DATA_LSB = 0;
    localparam int RSP_DATA_LSB = 0;

    function automatic int req_strb_lsb(int data_w);
        return data_w;
    endfunction

    function automatic int req_addr_lsb(int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int req_write_bit(int addr_w, int data_w);
        return addr_w + data_w / 8 + data_w;
    endfunction

    function automatic int req_width(int addr_w, int data_w);
        return 1 + addr_w + data_w / 8 + data_w;
    endfunction

    function automatic int rsp_err_bit(int data_w);
        return data_w;
    endfunction

    function automatic int rsp_width(int data_w);
        return 1 + data_w;
    endfunction

    // Wide enough to hold the limit itself, kept within 8..32 bits.
    function automatic int timeout_cnt_width(int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8)
            w = 8;
        else if (w > 32)
            w = 32;
        return w;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase cycles; expired flags the cycle that reaches the limit.
module apb_timeout_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    // count holds completed wait cycles, so count_inc numbers the current one
    assign count_inc = count + 1'b1;
    assign expired   = enable && (count_inc == limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count_inc;
    end

endmodule

// File: rtl/apb4_master_engine.sv
// Pops request FIFO entries, runs each as one APB4 transfer, pushes one response each.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb4_master_engine
    import apb_bridge_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 32,
    parameter int         DATA_WIDTH     = 32,
    parameter int         REQ_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH / 8 + DATA_WIDTH,
    parameter int         RSP_WIDTH      = 1 + DATA_WIDTH,
    parameter logic [2:0] PPROT_VAL      = 3'b000,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [REQ_WIDTH-1:0]    req_dataout,
    input  logic                    req_empty,
    output logic                    req_r_en,
    output logic [RSP_WIDTH-1:0]    rsp_datain,
    input  logic                    rsp_full,
    output logic                    rsp_w_en,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    output logic                    busy
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int STRB_LSB = req_strb_lsb(DATA_WIDTH);
    localparam int ADDR_LSB = req_addr_lsb(DATA_WIDTH);
    localparam int WR_BIT   = req_write_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int ERR_BIT  = rsp_err_bit(DATA_WIDTH);

    generate
        if ((DATA_WIDTH % 8 != 0) || (REQ_WIDTH != req_width(ADDR_WIDTH, DATA_WIDTH)) ||
            (RSP_WIDTH != rsp_width(DATA_WIDTH)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
            $error("apb4_master_engine: inconsistent parameters");
        end
    endgenerate

    apb_state_e            state;
    apb_state_e            state_nxt;
    logic                  timeout_hit;
    logic                  req_wr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign req_wr = req_dataout[WR_BIT];

`ifdef APB_TIMEOUT_EN
    localparam int TO_CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

    apb_timeout_counter #(
        .CNT_W (TO_CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == SETUP),
        .enable  (state == ACCESS),
        .limit   (TO_CNT_W'(TIMEOUT_CYCLES)),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Bus fields only change in FETCH and otherwise hold their last transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
            PSTRB  <= '0;
        end else if (state == FETCH) begin
            PWRITE <= req_wr;
            PADDR  <= req_dataout[ADDR_LSB +: ADDR_WIDTH];
            PWDATA <= req_dataout[REQ_DATA_LSB +: DATA_WIDTH];
            PSTRB  <= req_wr ? req_dataout[STRB_LSB +: STRB_W] : '0;
        end
    end

    assign rd_data = PWRITE ? '0 : PRDATA;

    always_comb begin
        state_nxt  = state;
        req_r_en   = 1'b0;
        rsp_w_en   = 1'b0;
        rsp_datain = '0;
        case (state)
            IDLE: begin
                // Response space is reserved before popping; nobody else pushes.
                if (!reset && !req_empty && !rsp_full) begin
                    req_r_en  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH:  state_nxt = SETUP;
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    rsp_w_en                                = 1'b1;
                    rsp_datain[ERR_BIT]                     = PSLVERR;
                    rsp_datain[RSP_DATA_LSB +: DATA_WIDTH]  = rd_data;
                    state_nxt                               = IDLE;
                end else if (timeout_hit) begin
                    rsp_w_en            = 1'b1;
                    rsp_datain[ERR_BIT] = 1'b1;
                    state_nxt           = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign PSEL    = (state == SETUP) || (state == ACCESS);
    assign PENABLE = (state == ACCESS);
    assign busy    = (state != IDLE);
    assign PPROT   = PPROT_VAL;

endmodule

// File: tb/tb_apb4_master_engine.sv
// Self-checking bench: FIFO/slave models plus a transaction-level scoreboard.
module tb_apb4_master_engine;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int RQW = 1 + AW + SW + DW;
    localparam int RSW = 1 + DW;
    localparam int TO  = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [RQW-1:0] req_dataout;
    logic           req_empty;
    logic           req_r_en;
    logic [RSW-1:0] rsp_datain;
    logic           rsp_full;
    logic           rsp_w_en;
    logic           PSEL, PENABLE, PWRITE;
    logic [AW-1:0]  PADDR;
    logic [DW-1:0]  PWDATA, PRDATA;
    logic [SW-1:0]  PSTRB;
    logic [2:0]     PPROT;
    logic           PREADY, PSLVERR, busy;

    apb4_master_engine #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_dataout (req_dataout),
        .req_empty   (req_empty),
        .req_r_en    (req_r_en),
        .rsp_datain  (rsp_datain),
        .rsp_full    (rsp_full),
        .rsp_w_en    (rsp_w_en),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PPROT       (PPROT),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit [AW-1:0] addr;
        bit [SW-1:0] strb;
        bit [DW-1:0] data;
        int          waits;
        bit [DW-1:0] prdata;
        bit          err;
    } xfer_t;

    xfer_t          fifo_q[$];
    xfer_t          bus_q[$];
    logic [RSW-1:0] rsp_q[$];
    int             setup_cycs[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ren_cyc, psel_cyc, pen_cyc, push_cyc;
    int n_ren = 0, n_setup = 0, n_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [RSW-1:0] exp_rsp(input xfer_t t);
`ifdef APB_TIMEOUT_EN
        if (t.waits >= TO)
            return {1'b1, {DW{1'b0}}};
`endif
        return {t.err, t.wr ? {DW{1'b0}} : t.prdata};
    endfunction

    // Request FIFO, APB slave and bus monitor in one process.
    initial begin
        xfer_t          cur;
        logic [RQW-1:0] pend;
        bit             pend_v = 0;
        bit             drop_chk = 0;
        bit             prev_pen = 0;
        int             acc = 0;
        cur         = '{default: 0};
        req_dataout = '0;
        req_empty   = 1'b1;
        PREADY      = 1'b0;
        PRDATA      = '0;
        PSLVERR     = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (drop_chk) begin
                    chk("psel_drop_after_push", 64'(PSEL), 64'(0));
                    drop_chk = 0;
                end
                if (req_r_en) begin
                    chk("pop_when_nonempty", 64'(fifo_q.size() != 0), 64'(1));
                    if (fifo_q.size() != 0) begin
                        xfer_t t;
                        t      = fifo_q.pop_front();
                        pend   = {t.wr, t.addr, t.strb, t.data};
                        pend_v = 1;
                    end
                    ren_cyc = cyc;
                    n_ren++;
                end
                if (PSEL && !PENABLE) begin
                    psel_cyc = cyc;
                    setup_cycs.push_back(cyc);
                    n_setup++;
                    if (bus_q.size() == 0) begin
                        chk("unexpected_setup", 64'(1), 64'(0));
                    end else begin
                        cur = bus_q.pop_front();
                        chk("setup_pwrite", 64'(PWRITE), 64'(cur.wr));
                        chk("setup_paddr", 64'(PADDR), 64'(cur.addr));
                        chk("setup_pstrb", 64'(PSTRB), 64'(cur.wr ? cur.strb : 4'h0));
                        chk("setup_pwdata", 64'(PWDATA), 64'(cur.data));
                        chk("setup_pprot", 64'(PPROT), 64'(0));
                    end
                end
                if (PSEL && PENABLE && !prev_pen)
                    pen_cyc = cyc;
                if (rsp_w_en) begin
                    chk("push_with_space", 64'(rsp_full), 64'(0));
                    chk("access_hold_paddr", 64'(PADDR), 64'(cur.addr));
                    chk("access_hold_pwrite", 64'(PWRITE), 64'(cur.wr));
                    push_cyc = cyc;
                    n_rsp++;
                    drop_chk = 1;
                    if (rsp_q.size() == 0)
                        chk("unexpected_push", 64'(1), 64'(0));
                    else
                        chk("rsp_datain", 64'(rsp_datain), 64'(rsp_q.pop_front()));
                end
            end
            prev_pen = PENABLE;

            @(posedge clk);
            #1;
            if (pend_v) begin
                req_dataout = pend;
                pend_v      = 0;
            end else begin
                req_dataout = RQW'({$urandom, $urandom, $urandom});
            end
            req_empty = (fifo_q.size() == 0);
            if (PSEL && PENABLE) begin
                PREADY = (acc == cur.waits);
                acc++;
            end else begin
                PREADY = 1'b0;
                acc    = 0;
            end
            PRDATA  = PREADY ? cur.prdata : $urandom;
            PSLVERR = PREADY ? cur.err : 1'($urandom_range(0, 1));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic add(input bit wr, input bit [AW-1:0] a, input bit [SW-1:0] s,
                       input bit [DW-1:0] d, input int w, input bit [DW-1:0] pr, input bit e);
        xfer_t t;
        t.wr = wr; t.addr = a; t.strb = s; t.data = d;
        t.waits = w; t.prdata = pr; t.err = e;
        fifo_q.push_back(t);
        bus_q.push_back(t);
        rsp_q.push_back(exp_rsp(t));
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || rsp_q.size() != 0 || busy) && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_drained"}, 64'(n < budget), 64'(1));
        step(1);
    endtask

    initial begin
        int base, base_s, n;
        reset    = 1'b1;
        rsp_full = 1'b0;
        step(3);
        chk("rst_psel", 64'(PSEL), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_pwrite", 64'(PWRITE), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_pwdata", 64'(PWDATA), 64'(0));
        chk("rst_pstrb", 64'(PSTRB), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_r_en", 64'(req_r_en), 64'(0));
        chk("rst_rsp_w_en", 64'(rsp_w_en), 64'(0));
        chk("rst_rsp_datain", 64'(rsp_datain), 64'(0));
        reset = 1'b0;
        step(2);

        // Zero-wait write
        add(1, 32'h1000, 4'hF, 32'hDEADBEEF, 0, 32'h55AA55AA, 0);
        drain("t1", 50);
        chk("t1_psel_after_pop", 64'(psel_cyc - ren_cyc), 64'(2));
        chk("t1_penable_after_psel", 64'(pen_cyc - psel_cyc), 64'(1));
        chk("t1_push_on_access", 64'(push_cyc - pen_cyc), 64'(0));
        chk("t1_hold_paddr_idle", 64'(PADDR), 64'(32'h1000));

        // Read with two wait states
        add(0, 32'h2004, 4'hA, 32'h11111111, 2, 32'hCAFEF00D, 0);
        drain("t2", 50);
        chk("t2_access_len", 64'(push_cyc - pen_cyc + 1), 64'(3));

        // Slave error on read, following write still issued
        base = n_rsp;
        add(0, 32'h3000, 4'h3, 32'h0, 1, 32'h12345678, 1);
        add(1, 32'h3004, 4'h1, 32'hA5, 0, 32'hFFFFFFFF, 1);
        drain("t3", 60);
        chk("t3_rsp_count", 64'(n_rsp - base), 64'(2));

        // Response FIFO full blocks popping
        rsp_full = 1'b1;
        base     = n_ren;
        base_s   = n_setup;
        add(1, 32'h4000, 4'h3, 32'h01020304, 0, 32'h0, 0);
        add(0, 32'h4004, 4'hF, 32'h0, 0, 32'h0BADBEEF, 0);
        add(1, 32'h4008, 4'h8, 32'hF0F0F0F0, 0, 32'h0, 1);
        step(10);
        chk("t4_no_pop_when_full", 64'(n_ren - base), 64'(0));
        chk("t4_no_psel_when_full", 64'(n_setup - base_s), 64'(0));
        chk("t4_idle_when_full", 64'(busy), 64'(0));
        setup_cycs.delete();
        rsp_full = 1'b0;
        drain("t4", 60);
        chk("t4_setup_count", 64'(setup_cycs.size()), 64'(3));
        if (setup_cycs.size() == 3) begin
            chk("t4_spacing_a", 64'(setup_cycs[1] - setup_cycs[0]), 64'(4));
            chk("t4_spacing_b", 64'(setup_cycs[2] - setup_cycs[1]), 64'(4));
        end

        // Reset during ACCESS abandons the transfer
        add(0, 32'h5000, 4'h0, 32'h0, 50, 32'h77777777, 0);
        n = 0;
        while (!PENABLE && n < 20) begin
            step(1);
            n++;
        end
        chk("t5_reached_access", 64'(PENABLE), 64'(1));
        step(2);
        base  = n_rsp;
        reset = 1'b1;
        #1;
        chk("t5_psel_on_reset", 64'(PSEL), 64'(0));
        chk("t5_penable_on_reset", 64'(PENABLE), 64'(0));
        chk("t5_rsp_w_en_on_reset", 64'(rsp_w_en), 64'(0));
        chk("t5_busy_on_reset", 64'(busy), 64'(0));
        void'(rsp_q.pop_front());
        step(2);
        reset = 1'b0;
        step(1);
        add(1, 32'h5004, 4'h6, 32'h89ABCDEF, 1, 32'h0, 0);
        drain("t5", 60);
        chk("t5_only_new_rsp", 64'(n_rsp - base), 64'(1));

`ifdef APB_TIMEOUT_EN
        // Stuck slave times out; PREADY on the limit cycle still completes normally
        add(0, 32'h6000, 4'h0, 32'h0, 1000, 32'h13579BDF, 0);
        drain("t6", 100);
        chk("t6_timeout_len", 64'(push_cyc - pen_cyc + 1), 64'(TO));
        add(0, 32'h6004, 4'h0, 32'h0, TO - 1, 32'h2468ACE0, 0);
        drain("t6b", 100);
        chk("t6_limit_ready_len", 64'(push_cyc - pen_cyc + 1), 64'(TO));
`endif

        // Randomized traffic
        base = n_rsp;
        repeat (40) begin
            add(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
            step($urandom_range(0, 3));
        end
        drain("rand", 2000);
        chk("rand_rsp_count", 64'(n_rsp - base), 64'(40));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
